// File: rtl/weight_arb_pkg.sv
// Shared types for the weight_medium arbiters: FSM states, operation kind, width helper.
package weight_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

  // $clog2 that never collapses to a zero-width vector.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/weight_medium_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending requester after ptr, wrapping N-1 -> 0.
module rr_picker
  import weight_arb_pkg::*;
#(
  parameter  int unsigned N  = 2,
  localparam int unsigned IW = clog2_min1(N)
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  // Scan N slots starting one past the pointer; the first hit wins.
  always_comb begin : pick
    int unsigned c;
    winner_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    c        = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!valid_c && pending[IW'(c)]) begin
        valid_c            = 1'b1;
        idx_c              = IW'(c);
        winner_c[IW'(c)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_medium_arbiter.sv
// Round-robin arbiter sharing one weight_medium among NUM_REQ requesters,
// one read or write in flight at a time, with optional wait timeout.
module weight_medium_arbiter
  import weight_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned ADDRS      = 256,
  parameter  int unsigned BRAM_WIDTH = 64,
  parameter  int unsigned PIECES     = 48,
  parameter  int unsigned TIMEOUT    = 4096,
  localparam int unsigned ADDR_SIZE  = $clog2(ADDRS),
  localparam int unsigned WIDTH      = PIECES * BRAM_WIDTH
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_REQ-1:0]           req_read_in,
  input  logic [NUM_REQ-1:0]           req_write_in,
  input  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_in,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data_in,
  output logic [NUM_REQ-1:0]           grant_out,
  output logic [NUM_REQ-1:0]           done_out,
  output logic [NUM_REQ-1:0]           error_out,
  output logic [WIDTH-1:0]             rdata_out,
  output logic [ADDR_SIZE-1:0]         med_addr_out,
  output logic [WIDTH-1:0]             med_data_out,
  output logic                         med_read_en_out,
  output logic                         med_write_en_out,
  input  logic [WIDTH-1:0]             med_weight_in,
  input  logic                         med_finished_in
);

  localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
  localparam int unsigned CNT_W = clog2_min1(TIMEOUT + 1);

  state_t             state;
  op_t                op_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] pending_c;
  logic [NUM_REQ-1:0] win_onehot_c;
  logic [IDX_W-1:0]   win_idx_c;
  logic               win_valid_c;
  logic [NUM_REQ-1:0] owner_c;
  logic               timeout_c;

  assign pending_c = req_read_in | req_write_in;
  assign owner_c   = NUM_REQ'(1) << idx_q;
  assign timeout_c = (TIMEOUT != 0) && ((wait_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT));

  rr_picker #(
    .N(NUM_REQ)
  ) u_rr_picker (
    .pending  (pending_c),
    .ptr      (rr_ptr),
    .winner_c (win_onehot_c),
    .idx_c    (win_idx_c),
    .valid_c  (win_valid_c)
  );

  // Arbitration FSM; the medium address/data outputs double as the latched request.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= IDLE;
      op_q             <= OP_READ;
      idx_q            <= '0;
      rr_ptr           <= IDX_W'(NUM_REQ - 1);
      wait_cnt         <= '0;
      grant_out        <= '0;
      done_out         <= '0;
      error_out        <= '0;
      rdata_out        <= '0;
      med_addr_out     <= '0;
      med_data_out     <= '0;
      med_read_en_out  <= 1'b0;
      med_write_en_out <= 1'b0;
    end else begin
      done_out         <= '0;
      error_out        <= '0;
      med_read_en_out  <= 1'b0;
      med_write_en_out <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid_c) begin
            state        <= ISSUE;
            idx_q        <= win_idx_c;
            grant_out    <= win_onehot_c;
            wait_cnt     <= '0;
            med_addr_out <= req_addr_in[32'(win_idx_c)*ADDR_SIZE +: ADDR_SIZE];
            med_data_out <= req_data_in[32'(win_idx_c)*WIDTH +: WIDTH];
            // A simultaneous read and write from one requester performs the write.
            if (req_write_in[win_idx_c]) begin
              op_q             <= OP_WRITE;
              med_write_en_out <= 1'b1;
            end else begin
              op_q            <= OP_READ;
              med_read_en_out <= 1'b1;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (med_finished_in) begin
            if (op_q == OP_READ) rdata_out <= med_weight_in;
            done_out <= owner_c;
            state    <= DONE;
          end else if (timeout_c) begin
            done_out  <= owner_c;
            error_out <= owner_c;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          rr_ptr       <= idx_q;
          grant_out    <= '0;
          med_addr_out <= '0;
          med_data_out <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_medium_arbiter.sv
// Directed bench for weight_medium_arbiter with a small behavioural weight_medium.
module tb_weight_medium_arbiter;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned ADDRS      = 256;
  localparam int unsigned BRAM_WIDTH = 64;
  localparam int unsigned PIECES     = 4;
  localparam int unsigned TIMEOUT    = 8;
  localparam int unsigned AW         = 8;
  localparam int unsigned W          = PIECES * BRAM_WIDTH;
  localparam int unsigned MED_LAT    = 4;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_REQ-1:0]      req_read, req_write;
  logic [NUM_REQ*AW-1:0]   req_addr;
  logic [NUM_REQ*W-1:0]    req_data;
  logic [NUM_REQ-1:0]      grant, done, error;
  logic [W-1:0]            rdata, med_data, med_weight;
  logic [AW-1:0]           med_addr;
  logic                    rd_en, wr_en, med_fin_q, stray_fin, hang;

  always #5 clk = ~clk;

  weight_medium_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDRS(ADDRS), .BRAM_WIDTH(BRAM_WIDTH),
    .PIECES(PIECES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_n),
    .req_read_in      (req_read),
    .req_write_in     (req_write),
    .req_addr_in      (req_addr),
    .req_data_in      (req_data),
    .grant_out        (grant),
    .done_out         (done),
    .error_out        (error),
    .rdata_out        (rdata),
    .med_addr_out     (med_addr),
    .med_data_out     (med_data),
    .med_read_en_out  (rd_en),
    .med_write_en_out (wr_en),
    .med_weight_in    (med_weight),
    .med_finished_in  (med_fin_q | stray_fin)
  );

  function automatic logic [W-1:0] init_word(input logic [AW-1:0] a);
    return {(W/8){a}};
  endfunction

  // Behavioural medium: finished pulses MED_LAT cycles after an enable.
  logic [W-1:0] mem [ADDRS];
  bit           wv  [ADDRS];
  int unsigned  med_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      med_fin_q <= 1'b0;
      med_cnt   <= 0;
    end else begin
      med_fin_q <= 1'b0;
      if (!hang && (rd_en || wr_en)) begin
        med_cnt <= MED_LAT - 1;
        if (wr_en) begin
          mem[med_addr] <= med_data;
          wv[med_addr]  <= 1'b1;
        end else begin
          med_weight <= wv[med_addr] ? mem[med_addr] : init_word(med_addr);
        end
      end else if (med_cnt != 0) begin
        med_cnt   <= med_cnt - 1;
        med_fin_q <= (med_cnt == 1);
      end
    end
  end

  // Activity monitor.
  int unsigned        n_rd = 0, n_wr = 0, n_done0 = 0, n_done1 = 0;
  logic [AW-1:0]      last_addr;
  logic [W-1:0]       last_wdata;
  logic [NUM_REQ-1:0] glog [$];
  always @(posedge clk) begin
    if (rd_en) begin
      n_rd      <= n_rd + 1;
      last_addr <= med_addr;
      glog.push_back(grant);
    end
    if (wr_en) begin
      n_wr       <= n_wr + 1;
      last_addr  <= med_addr;
      last_wdata <= med_data;
    end
    if (done[0]) n_done0 <= n_done0 + 1;
    if (done[1]) n_done1 <= n_done1 + 1;
  end

  int unsigned n_vec = 0, n_miss = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op from requester r; returns cycles to its done pulse and error_out then.
  task automatic run_op(input int r, input bit rd, input bit wr, input logic [AW-1:0] a,
                        input logic [W-1:0] d, output int lat, output logic [NUM_REQ-1:0] err);
    req_read[r]          = rd;
    req_write[r]         = wr;
    req_addr[r*AW +: AW] = a;
    req_data[r*W +: W]   = d;
    lat = 0;
    err = '0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done[r]) begin
        err = error;
        break;
      end
    end
    req_read[r]  = 1'b0;
    req_write[r] = 1'b0;
    @(negedge clk);
  endtask

  int unsigned        rd0, wr0, d0, d1, ndone, cyc, base;
  int                 lat;
  logic [NUM_REQ-1:0] err;
  logic [W-1:0]       pat_a5, pat_3c;
  logic [NUM_REQ-1:0] exp_g [4];

  initial begin
    pat_a5 = {(W/8){8'hA5}};
    pat_3c = {(W/8){8'h3C}};
    exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst_n = 1'b0; req_read = '0; req_write = '0; req_addr = '0; req_data = '0;
    stray_fin = 1'b0; hang = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", W'(grant), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_rdata", rdata, W'(0));
    check("rst_med_addr", W'(med_addr), W'(0));
    check("rst_en", W'({rd_en, wr_en}), W'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Single read of address 5 by requester 0.
    rd0 = n_rd; d0 = n_done0; d1 = n_done1;
    run_op(0, 1'b1, 1'b0, 8'd5, '0, lat, err);
    check("t1_latency", W'(lat), W'(6));
    check("t1_rd_pulses", W'(n_rd - rd0), W'(1));
    check("t1_addr", W'(last_addr), W'(5));
    check("t1_done0", W'(n_done0 - d0), W'(1));
    check("t1_done1", W'(n_done1 - d1), W'(0));
    check("t1_err", W'(err), W'(0));
    check("t1_rdata", rdata, {(W/8){8'h05}});

    // Requester 1 writes A5.. to 17 then reads it back.
    wr0 = n_wr;
    run_op(1, 1'b0, 1'b1, 8'd17, pat_a5, lat, err);
    check("t2_wr_pulses", W'(n_wr - wr0), W'(1));
    check("t2_wdata", last_wdata, pat_a5);
    check("t2_rdata_after_wr", rdata, {(W/8){8'h05}});
    run_op(1, 1'b1, 1'b0, 8'd17, '0, lat, err);
    check("t2_readback", rdata, pat_a5);

    // Both requesters held: grants must alternate starting with 0.
    base = glog.size();
    req_addr = {8'd17, 8'd5};
    req_read = 2'b11;
    ndone = 0; cyc = 0;
    while (ndone < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done != '0) ndone++;
    end
    req_read = '0;
    @(negedge clk);
    check("t3_ndone", W'(ndone), W'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("t3_grant%0d", k),
            W'((base + k < glog.size()) ? glog[base + k] : 2'b00), W'(exp_g[k]));

    // Read and write together on requester 0: write only.
    rd0 = n_rd; wr0 = n_wr;
    run_op(0, 1'b1, 1'b1, 8'd3, pat_3c, lat, err);
    check("t4_latency", W'(lat), W'(6));
    check("t4_rd_pulses", W'(n_rd - rd0), W'(0));
    check("t4_wr_pulses", W'(n_wr - wr0), W'(1));
    check("t4_mem3", wv[3] ? mem[3] : '0, pat_3c);
    check("t4_rdata_kept", rdata, pat_a5);

    // Medium never finishes: abort after TIMEOUT wait cycles.
    hang = 1'b1;
    run_op(0, 1'b1, 1'b0, 8'd5, '0, lat, err);
    check("t5_latency", W'(lat), W'(2 + TIMEOUT));
    check("t5_error", W'(err), W'(2'b01));
    check("t5_rdata_kept", rdata, pat_a5);
    hang = 1'b0;
    run_op(0, 1'b1, 1'b0, 8'd5, '0, lat, err);
    check("t5_next_latency", W'(lat), W'(6));
    check("t5_next_error", W'(err), W'(0));
    check("t5_next_rdata", rdata, {(W/8){8'h05}});

    // Reset during WAIT, stray finish in IDLE, then fresh arbitration.
    d0 = n_done0; d1 = n_done1;
    req_addr[AW +: AW] = 8'd5;
    req_read[1] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_grant", W'(grant), W'(0));
    check("t6_rst_addr", W'(med_addr), W'(0));
    check("t6_rst_rdata", rdata, W'(0));
    req_read = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stray_fin = 1'b1;
    @(negedge clk);
    stray_fin = 1'b0;
    @(negedge clk);
    check("t6_stray_done", W'(done), W'(0));
    check("t6_stray_rdata", rdata, W'(0));
    check("t6_no_done", W'((n_done0 - d0) + (n_done1 - d1)), W'(0));
    req_addr = {8'd17, 8'd5};
    req_read = 2'b11;
    @(negedge clk);
    check("t6_first_grant", W'(grant), W'(2'b01));
    req_read = '0;
    repeat (10) @(negedge clk);
    check("t6_rdata", rdata, {(W/8){8'h05}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
